multicycle_ctrl: RTL and testbench

Moore-style control FSM for the multi-cycle RV32I datapath. Each cycle it sequences the shared ALU by driving the operand-mux selects, the ALU operation, and the PC/IR/memory/register-file enables. One ALU serves PC increment, branch-target, address and result computation in successive states. The block sits between the instruction register and the datapath, with one external memory handshake.

---
 rtl/ctrl_pkg.sv | 73 +++++++
 rtl/alu_op_decoder.sv | 29 ++
 rtl/multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, ALU ops,
// opcodes, operand-mux selects and the branch-condition helper.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_LUI,
    S_AUIPC,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JAL,
    S_ALU_WB,
    S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;
  localparam logic [1:0] SRC_A_ZERO  = 2'd3;

  localparam logic [1:0] SRC_B_RS2    = 2'd0;
  localparam logic [1:0] SRC_B_IMM    = 2'd1;
  localparam logic [1:0] SRC_B_CONST4 = 2'd2;

  // funct3 010/011 are reserved branch encodings; they fall through as not taken.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       zero,
                                        input logic       lt,
                                        input logic       ltu);
    logic taken;
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational funct3/funct7_5 to ALU-operation map shared by the R-type
// and I-type execute states.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_reg,
  output logic [3:0] alu_op
);

  // For immediates funct7_5 is part of the immediate except on shifts, so only
  // SRAI honours it; ADDI never turns into a subtract.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style sequencing FSM for the multi-cycle RV32I datapath.
// Optional performance counters are enabled with MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  input  logic        mem_ready,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        pc_src,
  output logic        mem_addr_sel,
  output logic        wb_sel,
  output logic        illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_e     state_q;
  state_e     state_d;
  logic       is_reg;
  logic [3:0] dec_alu_op;

  assign is_reg = (state_q == S_EXEC_R);

  alu_op_decoder u_alu_op_decoder (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .is_reg   (is_reg),
    .alu_op   (dec_alu_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALU_ADD;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    pc_src       = 1'b0;
    mem_addr_sel = 1'b0;
    wb_sel       = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // PC+4 is written back in the same cycle the instruction word lands in IR.
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_CONST4;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OPC_OP:     state_d = S_EXEC_R;
          OPC_OP_IMM: state_d = S_EXEC_I;
          OPC_LOAD:   state_d = S_MEM_ADDR;
          OPC_STORE:  state_d = S_MEM_ADDR;
          OPC_BRANCH: state_d = S_BRANCH;
          OPC_JAL:    state_d = S_JAL;
          OPC_LUI:    state_d = S_LUI;
          OPC_AUIPC:  state_d = S_AUIPC;
          default:    state_d = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = dec_alu_op;
        state_d   = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = dec_alu_op;
        state_d   = S_ALU_WB;
      end

      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ALU_WB;
      end

      S_AUIPC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ALU_WB;
      end

      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end

      // Target was latched in ALUOUT during DECODE; the ALU now only compares.
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
        state_d   = S_FETCH;
      end

      // Link value (OLDPC+4) is computed while the jump target comes from ALUOUT.
      S_JAL: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_CONST4;
        pc_src    = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        illegal = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] cycle_cnt_d;
  logic [31:0] instret_cnt_q;
  logic [31:0] instret_cnt_d;

  // An instruction retires when control returns to FETCH from any working state.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_IDLE && state_q != S_TRAP) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE) begin
      instret_cnt_d = instret_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle schedule model
// plus directed checks; perf counters are covered when MULTICYCLE_CTRL_PERF_EN is set.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [8:0] C_IRW = 9'h100;
  localparam logic [8:0] C_PCW = 9'h080;
  localparam logic [8:0] C_MR  = 9'h040;
  localparam logic [8:0] C_MW  = 9'h020;
  localparam logic [8:0] C_RW  = 9'h010;
  localparam logic [8:0] C_PCS = 9'h008;
  localparam logic [8:0] C_MAS = 9'h004;
  localparam logic [8:0] C_WBS = 9'h002;
  localparam logic [8:0] C_ILL = 9'h001;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        alu_zero;
  logic        alu_lt;
  logic        alu_ltu;
  logic        mem_ready;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        ir_write;
  logic        pc_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        pc_src;
  logic        mem_addr_sel;
  logic        wb_sel;
  logic        illegal;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int          checks = 0;
  int          fails = 0;
  logic [16:0] expVec = 17'h0;
  bit          expValid = 1'b0;
  int          expCycle = 0;
  int          expInstret = 0;
  bit          prevIdle = 1'b1;
  int          cycleNo = 0;
  int          lastIrw = 0;
  int          irwDelta = 0;
  int          memWrTotal = 0;
  logic [3:0]  lastExecROp = 4'hF;
  logic        lastBranchPcw = 1'b0;
  logic [16:0] dutVec;

  assign dutVec = {alu_src_a, alu_src_b, alu_op, ir_write, pc_write, mem_read,
                   mem_write, reg_write, pc_src, mem_addr_sel, wb_sel, illegal};

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .alu_zero     (alu_zero),
    .alu_lt       (alu_lt),
    .alu_ltu      (alu_ltu),
    .mem_ready    (mem_ready),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .pc_src       (pc_src),
    .mem_addr_sel (mem_addr_sel),
    .wb_sel       (wb_sel),
    .illegal      (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo++;

  function automatic logic [16:0] mk(input int a, input int b, input int op, input logic [8:0] ctl);
    logic [1:0] a2;
    logic [1:0] b2;
    logic [3:0] op4;
    a2  = a[1:0];
    b2  = b[1:0];
    op4 = op[3:0];
    return {a2, b2, op4, ctl};
  endfunction

  // SUB and SRA sit one code above ADD and SRL; funct7_5 bumps to them.
  function automatic int aluOpModel(input logic [2:0] f3, input logic f7, input bit isReg);
    int baseOp [8];
    int alt;
    baseOp = '{0, 2, 3, 4, 5, 6, 8, 9};
    alt = (f7 && (f3 == 3'd5 || (f3 == 3'd0 && isReg))) ? 1 : 0;
    return baseOp[f3] + alt;
  endfunction

  function automatic bit takenModel(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (expValid) begin
      checks++;
      if (dutVec !== expVec) begin
        fails++;
        $display("[TB] FAIL ctrl_outputs cycle=%0d actual=%05h required=%05h", cycleNo, dutVec, expVec);
      end
`ifdef MULTICYCLE_CTRL_PERF_EN
      checks++;
      if (cycle_cnt !== expCycle[31:0]) begin
        fails++;
        $display("[TB] FAIL cycle_cnt cycle=%0d actual=%0d required=%0d", cycleNo, cycle_cnt, expCycle);
      end
      checks++;
      if (instret_cnt !== expInstret[31:0]) begin
        fails++;
        $display("[TB] FAIL instret_cnt cycle=%0d actual=%0d required=%0d", cycleNo, instret_cnt, expInstret);
      end
`endif
    end
    if (ir_write === 1'b1) begin
      irwDelta = cycleNo - lastIrw;
      lastIrw  = cycleNo;
    end
    if (mem_write === 1'b1) memWrTotal++;
    if (alu_src_a === 2'd2 && alu_src_b === 2'd0 && pc_src === 1'b0) lastExecROp = alu_op;
    if (alu_src_a === 2'd2 && pc_src === 1'b1) lastBranchPcw = pc_write;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic noise();
    alu_zero  = 1'($urandom_range(0, 1));
    alu_lt    = 1'($urandom_range(0, 1));
    alu_ltu   = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [16:0] v, input bit countable);
    expVec   = v;
    expValid = 1'b1;
    @(posedge clk);
    #1;
    if (countable) expCycle++;
  endtask

  task automatic doReset();
    expValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_outputs_zero", {15'd0, dutVec}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    checkOutput("reset_cycle_cnt", cycle_cnt, 32'd0);
    checkOutput("reset_instret_cnt", instret_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst        = 1'b0;
    expCycle   = 0;
    expInstret = 0;
    prevIdle   = 1'b1;
    noise();
    applyStimulus(17'h0, 1'b0);
  endtask

  task automatic writeBack();
    noise();
    applyStimulus(mk(0, 0, 0, C_RW), 1'b1);
  endtask

  // Expected per-cycle outputs for one instruction, derived from its schedule.
  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input int fw, input int mw, input logic z, input logic lt,
                          input logic ltu, input int abortAt);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
    if (!prevIdle) expInstret++;
    prevIdle = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      noise();
      mem_ready = (i == fw);
      applyStimulus(mk(0, 2, 0, C_MR | ((i == fw) ? (C_IRW | C_PCW) : 9'h0)), 1'b1);
    end
    noise();
    applyStimulus(mk(1, 1, 0, 9'h0), 1'b1);
    if (op == OP_R) begin
      noise();
      applyStimulus(mk(2, 0, aluOpModel(f3, f7, 1'b1), 9'h0), 1'b1);
      writeBack();
    end else if (op == OP_I) begin
      noise();
      applyStimulus(mk(2, 1, aluOpModel(f3, f7, 1'b0), 9'h0), 1'b1);
      writeBack();
    end else if (op == OP_LUI) begin
      noise();
      applyStimulus(mk(3, 1, 0, 9'h0), 1'b1);
      writeBack();
    end else if (op == OP_AUIPC) begin
      noise();
      applyStimulus(mk(1, 1, 0, 9'h0), 1'b1);
      writeBack();
    end else if (op == OP_LOAD || op == OP_STORE) begin
      noise();
      applyStimulus(mk(2, 1, 0, 9'h0), 1'b1);
      for (int i = 0; i <= mw; i++) begin
        if (op == OP_LOAD && i == abortAt) return;
        noise();
        mem_ready = (i == mw);
        applyStimulus(mk(0, 0, 0, (op == OP_LOAD) ? (C_MR | C_MAS) : (C_MW | C_MAS)), 1'b1);
      end
      if (op == OP_LOAD) begin
        noise();
        applyStimulus(mk(0, 0, 0, C_RW | C_WBS), 1'b1);
      end
    end else if (op == OP_BRANCH) begin
      mem_ready = 1'($urandom_range(0, 1));
      alu_zero  = z;
      alu_lt    = lt;
      alu_ltu   = ltu;
      applyStimulus(mk(2, 0, 1, C_PCS | (takenModel(f3, z, lt, ltu) ? C_PCW : 9'h0)), 1'b1);
    end else if (op == OP_JAL) begin
      noise();
      applyStimulus(mk(1, 2, 0, C_PCS | C_PCW), 1'b1);
      writeBack();
    end else begin
      for (int i = 0; i < 10; i++) begin
        noise();
        applyStimulus(mk(0, 0, 0, C_ILL), 1'b0);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [6:0] rOp;
    logic [2:0] rF3;
    logic       rF7;
    int         mwBefore;

    rst = 1'b0; opcode = 7'h0; funct3 = 3'h0; funct7_5 = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b0;
    doReset();

    runInstr(OP_R, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("add_alu_op", {28'd0, lastExecROp}, 32'd0);
    runInstr(OP_R, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("add_cpi", irwDelta, 32'd4);
    checkOutput("sub_alu_op", {28'd0, lastExecROp}, 32'd1);

    runInstr(OP_LOAD, 3'd2, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0, -1);
    runInstr(OP_I, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("lw_3wait_cpi", irwDelta, 32'd8);

    mwBefore = memWrTotal;
    runInstr(OP_STORE, 3'd2, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0, -1);
    runInstr(OP_LUI, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("sw_3wait_cpi", irwDelta, 32'd7);
    checkOutput("sw_mem_write_cycles", memWrTotal - mwBefore, 32'd4);

    runInstr(OP_BRANCH, 3'b001, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("bne_taken_pc_write", {31'd0, lastBranchPcw}, 32'd1);
    runInstr(OP_AUIPC, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("branch_cpi", irwDelta, 32'd3);
    runInstr(OP_BRANCH, 3'b001, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("bne_not_taken_pc_write", {31'd0, lastBranchPcw}, 32'd0);
    runInstr(OP_BRANCH, 3'b111, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, -1);
    checkOutput("bgeu_not_taken_pc_write", {31'd0, lastBranchPcw}, 32'd0);
    runInstr(OP_JAL, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    runInstr(OP_R, 3'd7, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("jal_cpi", irwDelta, 32'd4);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0: rOp = OP_R;
        1: rOp = OP_I;
        2: rOp = OP_LOAD;
        3: rOp = OP_STORE;
        4: rOp = OP_BRANCH;
        5: rOp = OP_JAL;
        6: rOp = OP_LUI;
        default: rOp = OP_AUIPC;
      endcase
      rF3 = 3'($urandom_range(0, 7));
      rF7 = 1'($urandom_range(0, 1));
      runInstr(rOp, rF3, rF7, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), -1);
    end

    runInstr(OP_LOAD, 3'd2, 1'b0, 0, 4, 1'b0, 1'b0, 1'b0, 2);
    doReset();
    runInstr(OP_R, 3'd4, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);

    runInstr(7'b1100111, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("jalr_trap_sticky", {31'd0, illegal}, 32'd1);
    doReset();
    checkOutput("trap_cleared_by_reset", {31'd0, illegal}, 32'd0);
    runInstr(7'b0001111, 3'd0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, -1);
    doReset();
    runInstr(7'b1110011, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    doReset();

`ifdef MULTICYCLE_CTRL_PERF_EN
    for (int n = 0; n < 3; n++) begin
      runInstr(OP_R, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    end
    expInstret++;
    noise();
    mem_ready = 1'b1;
    applyStimulus(mk(0, 2, 0, C_MR | C_IRW | C_PCW), 1'b1);
    checkOutput("perf_instret_3_adds", instret_cnt, 32'd3);
    checkOutput("perf_cycle_3_adds", cycle_cnt, 32'd13);
    doReset();
`endif

    expValid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
